// File: rtl/imem_arbiter.sv
// Two-port arbiter for a single-port synchronous instruction memory: CPU fetch (read-only)
// and program loader (read/write), with round-robin plus bounded loader lock priority.
module imem_arbiter #(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // fetch port
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   output logic              f_err,
   // loader port
   input  logic              l_req,
   input  logic              l_we,
   input  logic [31:0]       l_addr,
   input  logic [31:0]       l_wdata,
   input  logic              l_lock,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [31:0]       l_rdata,
   output logic              l_err,
   // memory port
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata
);

   localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
   localparam logic OwnF = 1'b0;
   localparam logic OwnL = 1'b1;

   logic            last_owner_q, last_owner_d;
   logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
   logic            rsp_vld_q, rsp_vld_d;
   logic            rsp_own_q, rsp_own_d;
   logic            rsp_err_q, rsp_err_d;
   logic            rsp_we_q, rsp_we_d;
   logic [31:0]     f_rdata_q, l_rdata_q;
   logic            f_err_q, l_err_q;

   logic            f_acc_err, l_acc_err, lock_ok;
   logic [31:0]     rsp_data;
   logic            unused_lo;

   // Loader byte offset carries no meaning for word accesses.
   assign unused_lo = ^l_addr[1:0];

   assign f_acc_err = (f_addr[1:0] != 2'b00) || (32'(f_addr[31:2]) >= DEPTH);
   assign l_acc_err = (32'(l_addr[31:2]) >= DEPTH);
   assign lock_ok   = (32'(lock_cnt_q) < LOCK_MAX);

   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (rst_n) begin
         if (f_req && l_req) begin
            if (last_owner_q == OwnL && l_lock && lock_ok) begin
               l_gnt = 1'b1;
            end else if (last_owner_q == OwnL) begin
               f_gnt = 1'b1;
            end else begin
               l_gnt = 1'b1;
            end
         end else begin
            f_gnt = f_req;
            l_gnt = l_req;
         end
      end
   end

   always_comb begin
      m_en    = (f_gnt && !f_acc_err) || (l_gnt && !l_acc_err);
      m_we    = l_gnt && !l_acc_err && l_we;
      m_wdata = l_wdata;
      m_addr  = '0;
      if (f_gnt) begin
         m_addr = f_addr[ADDR_W+1:2];
      end else if (l_gnt) begin
         m_addr = l_addr[ADDR_W+1:2];
      end
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (f_gnt) begin
         last_owner_d = OwnF;
      end else if (l_gnt) begin
         last_owner_d = OwnL;
      end

      lock_cnt_d = lock_cnt_q;
      if (!f_req || f_gnt) begin
         lock_cnt_d = '0;
      end else if (l_gnt && lock_ok) begin
         lock_cnt_d = lock_cnt_q + 1'b1;
      end

      rsp_vld_d = f_gnt || l_gnt;
      rsp_own_d = l_gnt ? OwnL : OwnF;
      rsp_err_d = f_gnt ? f_acc_err : l_acc_err;
      rsp_we_d  = l_gnt && l_we;
   end

   // Response outputs are live from m_rdata in the response cycle, then held.
   always_comb begin
      rsp_data = (rsp_err_q || rsp_we_q) ? 32'h0 : m_rdata;
      f_rvalid = rst_n && rsp_vld_q && (rsp_own_q == OwnF);
      l_rvalid = rst_n && rsp_vld_q && (rsp_own_q == OwnL);
      f_rdata  = 32'h0;
      f_err    = 1'b0;
      l_rdata  = 32'h0;
      l_err    = 1'b0;
      if (rst_n) begin
         f_rdata = f_rvalid ? rsp_data  : f_rdata_q;
         f_err   = f_rvalid ? rsp_err_q : f_err_q;
         l_rdata = l_rvalid ? rsp_data  : l_rdata_q;
         l_err   = l_rvalid ? rsp_err_q : l_err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_owner_q <= OwnL;
         lock_cnt_q   <= '0;
         rsp_vld_q    <= 1'b0;
         rsp_own_q    <= OwnF;
         rsp_err_q    <= 1'b0;
         rsp_we_q     <= 1'b0;
         f_rdata_q    <= 32'h0;
         f_err_q      <= 1'b0;
         l_rdata_q    <= 32'h0;
         l_err_q      <= 1'b0;
      end else begin
         last_owner_q <= last_owner_d;
         lock_cnt_q   <= lock_cnt_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_own_q    <= rsp_own_d;
         rsp_err_q    <= rsp_err_d;
         rsp_we_q     <= rsp_we_d;
         f_rdata_q    <= f_rdata;
         f_err_q      <= f_err;
         l_rdata_q    <= l_rdata;
         l_err_q      <= l_err;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table for issue/response timing plus hand-written
// round-robin, lock and mid-transaction reset sequences against a behavioural memory.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req, f_gnt, f_rvalid, f_err;
   logic [31:0] f_addr, f_rdata;
   logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
   logic [31:0] l_addr, l_wdata, l_rdata;
   logic        m_en, m_we;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata, m_rdata;

   logic [31:0] mem [1024];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.DEPTH(1024), .ADDR_W(10), .LOCK_MAX(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_gnt    (f_gnt),
      .f_rvalid (f_rvalid),
      .f_rdata  (f_rdata),
      .f_err    (f_err),
      .l_req    (l_req),
      .l_we     (l_we),
      .l_addr   (l_addr),
      .l_wdata  (l_wdata),
      .l_lock   (l_lock),
      .l_gnt    (l_gnt),
      .l_rvalid (l_rvalid),
      .l_rdata  (l_rdata),
      .l_err    (l_err),
      .m_en     (m_en),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata)
   );

   // Synchronous single-port memory: data registered one cycle after a read strobe.
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr] <= m_wdata;
         else      m_rdata     <= mem[m_addr];
      end
   end

   typedef struct {
      logic        fr;
      logic [31:0] fa;
      logic        lr;
      logic        lwe;
      logic [31:0] la;
      logic [31:0] lwd;
      logic        lk;
      logic [1:0]  gnt;   // {f_gnt, l_gnt}
      logic        men;
      logic        mwe;
      logic [9:0]  maddr;
      logic        fv;
      logic [31:0] fd;
      logic        fe;
      logic        lv;
      logic [31:0] ld;
      logic        le;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                        input logic [31:0] la, input logic [31:0] lwd, input logic lk);
      f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd; l_lock = lk;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0]    = 32'hA5A5_0000;
      mem[2]    = 32'h2002_0005;
      mem[1023] = 32'h0BAD_F00D;
      m_rdata   = 32'h0;

      //          fr    fa       lr    lwe   la        lwd           lk   gnt    men   mwe   maddr    fv    fd             fe    lv    ld             le
      vecs[0]  = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 2'b10, 1'b1, 1'b0, 10'h2,   1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
      vecs[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 2'b01, 1'b1, 1'b1, 10'h4,   1'b1, 32'h2002_0005, 1'b0, 1'b0, 32'h0,         1'b0};
      vecs[2]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 2'b10, 1'b1, 1'b0, 10'h4,   1'b0, 32'h2002_0005, 1'b0, 1'b1, 32'h0,         1'b0};
      vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 10'h0,   1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b0};
      vecs[4]  = '{1'b1, 32'h10,  1'b1, 1'b0, 32'h8,    32'h0,        1'b0, 2'b01, 1'b1, 1'b0, 10'h2,   1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b0};
      vecs[5]  = '{1'b1, 32'h10,  1'b1, 1'b0, 32'h8,    32'h0,        1'b0, 2'b10, 1'b1, 1'b0, 10'h4,   1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 32'h2002_0005, 1'b0};
      vecs[6]  = '{1'b1, 32'h10,  1'b1, 1'b0, 32'h8,    32'h0,        1'b0, 2'b01, 1'b1, 1'b0, 10'h2,   1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'h2002_0005, 1'b0};
      vecs[7]  = '{1'b1, 32'h6,   1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 2'b10, 1'b0, 1'b0, 10'h1,   1'b0, 32'hDEADBEEF,  1'b0, 1'b1, 32'h2002_0005, 1'b0};
      vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b0, 2'b01, 1'b0, 1'b0, 10'h0,   1'b1, 32'h0,         1'b1, 1'b0, 32'h2002_0005, 1'b0};
      vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 10'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1};
      vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,    32'h0,        1'b0, 2'b01, 1'b1, 1'b0, 10'h0,   1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
      vecs[11] = '{1'b1, 32'hFFC, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 2'b10, 1'b1, 1'b0, 10'h3FF, 1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0000, 1'b0};
      vecs[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 10'h0,   1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'hA5A5_0000, 1'b0};

      // Reset with both requesting: everything quiet.
      rst_n = 1'b0;
      drive(1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'h1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #3;
      chk("rst f_gnt", 32'(f_gnt), 32'h0);
      chk("rst l_gnt", 32'(l_gnt), 32'h0);
      chk("rst m_en", 32'(m_en), 32'h0);
      chk("rst m_we", 32'(m_we), 32'h0);
      chk("rst f_rvalid", 32'(f_rvalid), 32'h0);
      chk("rst l_rvalid", 32'(l_rvalid), 32'h0);
      chk("rst f_rdata", f_rdata, 32'h0);
      chk("rst l_rdata", l_rdata, 32'h0);
      chk("rst f_err", 32'(f_err), 32'h0);
      chk("rst l_err", 32'(l_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lwe, vecs[i].la, vecs[i].lwd,
               vecs[i].lk);
         #3;
         chk($sformatf("v%0d gnt", i), 32'({f_gnt, l_gnt}), 32'(vecs[i].gnt));
         chk($sformatf("v%0d m_en", i), 32'(m_en), 32'(vecs[i].men));
         chk($sformatf("v%0d m_we", i), 32'(m_we), 32'(vecs[i].mwe));
         chk($sformatf("v%0d m_addr", i), 32'(m_addr), 32'(vecs[i].maddr));
         chk($sformatf("v%0d f_rvalid", i), 32'(f_rvalid), 32'(vecs[i].fv));
         chk($sformatf("v%0d f_rdata", i), f_rdata, vecs[i].fd);
         chk($sformatf("v%0d f_err", i), 32'(f_err), 32'(vecs[i].fe));
         chk($sformatf("v%0d l_rvalid", i), 32'(l_rvalid), 32'(vecs[i].lv));
         chk($sformatf("v%0d l_rdata", i), l_rdata, vecs[i].ld);
         chk($sformatf("v%0d l_err", i), 32'(l_err), 32'(vecs[i].le));
         @(negedge clk);
      end

      // Round robin after reset: F, L, F, L; responses on the matching port.
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
         else       drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
         #3;
         if (k < 4) begin
            chk($sformatf("rr%0d f_gnt", k), 32'(f_gnt), 32'(k % 2 == 0));
            chk($sformatf("rr%0d l_gnt", k), 32'(l_gnt), 32'(k % 2 == 1));
         end
         chk($sformatf("rr%0d f_rvalid", k), 32'(f_rvalid), 32'(k % 2 == 1));
         chk($sformatf("rr%0d l_rvalid", k), 32'(l_rvalid), 32'(k > 0 && k % 2 == 0));
         if (k % 2 == 1) chk($sformatf("rr%0d f_rdata", k), f_rdata, 32'h2002_0005);
         if (k > 0 && k % 2 == 0) chk($sformatf("rr%0d l_rdata", k), l_rdata, 32'hDEADBEEF);
         @(negedge clk);
      end

      // Lock: 8 loader grants then fetch; solo loader unbounded; bound re-applies.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 38; k++) begin
         logic exp_f;
         logic fr;
         fr    = !(k >= 9 && k < 29);
         exp_f = (k == 8) || (k == 37);
         drive(fr, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
         #3;
         chk($sformatf("lk%0d f_gnt", k), 32'(f_gnt), 32'(exp_f));
         chk($sformatf("lk%0d l_gnt", k), 32'(l_gnt), 32'(!exp_f));
         @(negedge clk);
      end

      // Reset the cycle after a fetch grant: the pending response is dropped.
      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #3;
      chk("mr grant f_gnt", 32'(f_gnt), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      #3;
      chk("mr f_rvalid", 32'(f_rvalid), 32'h0);
      chk("mr l_rvalid", 32'(l_rvalid), 32'h0);
      chk("mr gnt", 32'({f_gnt, l_gnt}), 32'h0);
      chk("mr m_en", 32'(m_en), 32'h0);
      chk("mr f_rdata", f_rdata, 32'h0);
      chk("mr f_err", 32'(f_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #3;
      chk("mr post f_gnt", 32'(f_gnt), 32'h1);
      chk("mr post l_gnt", 32'(l_gnt), 32'h0);
      chk("mr post f_rvalid", 32'(f_rvalid), 32'h0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #3;
      chk("mr resp f_rvalid", 32'(f_rvalid), 32'h1);
      chk("mr resp f_rdata", f_rdata, 32'h2002_0005);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory (synchronous read, registered data one cycle after address) between two requesters: the CPU fetch port (read-only) and the program loader/debug port (read/write).
- Performs request/grant arbitration and drives the memory address, enable and write strobes.
- Routes the one-cycle-late read data back to the granted requester and flags misaligned or out-of-range accesses.
- Sits between the fetch stage and the instruction memory; the loader uses it to download programs before and during execution.

Parameters:
- DEPTH, 1024: memory size in 32-bit words.
- ADDR_W, 10: word-index width on the memory side (2^ADDR_W >= DEPTH).
- LOCK_MAX, 8: maximum consecutive loader grants under lock while fetch is waiting.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- f_req  in  1  fetch request; held until f_gnt.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid.
- f_rdata  out  32  fetch instruction word.
- f_err  out  1  fetch error, qualified by f_rvalid.
- l_req  in  1  loader request; held until l_gnt.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_lock  in  1  loader requests back-to-back priority.
- l_gnt  out  1  loader accepted this cycle (combinational).
- l_rvalid  out  1  loader response/ack valid.
- l_rdata  out  32  loader read data.
- l_err  out  1  loader error, qualified by l_rvalid.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write strobe.
- m_addr  out  ADDR_W  memory word index.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid the cycle after a read m_en.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Clears last_owner (to loader, so fetch wins the first tie), lock_cnt, the response-pending flag and all rvalid/err/rdata registers.
  - Gnt outputs and m_en/m_we are 0 while rst_n is low.
  - A response pending when reset is applied is discarded; no rvalid is produced after reset.
- Arbitration (combinational, each cycle):
  - Only one requester is granted per cycle.
  - Single requester: granted.
  - Both requesting: grant the requester that was not last_owner (round robin).
  - Exception: if last_owner = loader, l_lock = 1 and lock_cnt < LOCK_MAX, the loader wins.
- lock_cnt:
  - Increments on each loader grant made while f_req = 1.
  - Clears on any fetch grant, or on any cycle where f_req = 0.
  - When lock_cnt reaches LOCK_MAX, the next contested cycle goes to fetch.
- Address checks:
  - Word index = addr[ADDR_W+1:2].
  - Fetch with f_addr[1:0] != 0 is misaligned. Loader low bits are ignored.
  - Out of range: addr[31:2] >= DEPTH.
  - An erroneous access is still granted, but m_en = 0.
- Issue on grant, same cycle:
  - m_en = 1 (unless error), m_we = l_we for the loader and 0 for fetch.
  - m_addr is driven from the granted requester; m_wdata = l_wdata.
- Response, exactly one cycle after the grant:
  - The owning requester's rvalid pulses for one cycle.
  - Read: rdata = m_rdata, err = 0.
  - Write: ack with rdata = 0.
  - Error: err = 1, rdata = 0.
  - The non-owner's rvalid stays 0.
  - Throughput is one access per cycle, with grants back to back.
- rdata and err hold their value until the next rvalid for that port.
- Simultaneous events:
  - A new grant in the same cycle as the previous response is allowed.
  - The response register is updated from the owner tag captured at grant.
- No grant occurs without a req. A req dropped before gnt is a protocol violation; behaviour is undefined, but the arbiter must not deadlock.

Test Plan:
- Reset then fetch only: f_req with f_addr = 0x8, memory word 2 = 0x2002_0005 -> f_gnt same cycle, m_addr = 2, f_rvalid next cycle with f_rdata = 0x2002_0005, f_err = 0.
- Loader write then fetch read: l_we = 1, l_addr = 0x10, l_wdata = 0xDEADBEEF -> m_we = 1, m_addr = 4, l_rvalid next cycle. Then fetch 0x10 -> f_rdata = 0xDEADBEEF.
- Both requesting continuously, l_lock = 0 -> grants alternate F, L, F, L starting with F after reset; each rvalid arrives on the correct port.
- l_lock = 1 with both requesting, LOCK_MAX = 8 -> 8 consecutive loader grants, then 1 fetch grant. If f_req is dropped, the loader is granted indefinitely.
- Errors: f_addr = 0x6 -> f_err = 1 with m_en = 0. l_addr = 0x1000 (DEPTH = 1024) -> l_err = 1, l_rdata = 0, no memory write.
- rst_n asserted the cycle after a fetch grant -> no f_rvalid, all outputs 0. First post-reset contested cycle grants fetch.
